// File: rtl/err_inj_pkg.sv
// rtl/err_inj_pkg.sv - shared encodings for the serial bit-error injector
// Contents: mode encodings, FSM state type, LFSR seed/tap constants.
// Optional feature macro used by the consumers: ERR_INJECT_LFSR_EN.
package err_inj_pkg;

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_MASK  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_LFSR  = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/err_inj_lfsr16.sv
// rtl/err_inj_lfsr16.sv - 16-bit Fibonacci LFSR for random error positions
// Ports:
//   clk     in  1   system clock, rising edge
//   rst     in  1   synchronous active-high reset, loads LFSR_SEED
//   advance in  1   step the register by one position
//   value   out 16  current register contents
// Only instantiated when ERR_INJECT_LFSR_EN is defined.
module err_inj_lfsr16
  import err_inj_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] value
);

  logic feedback;

  assign feedback = ^(value & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/error_inject_serial_p.sv
// rtl/error_inject_serial_p.sv - frame-aligned serial bit-error injector
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   d_in, strobe_in          serial data bit and its valid qualifier
//   frame_start              marks d_in as bit 0 of a new frame
//   mode                     00 pass, 01 mask, 10 burst, 11 LFSR single bit
//   error_mask               per-bit inversion mask (mode 01)
//   error_pos, burst_len     burst start and length (mode 10)
//   d_out, strobe_out        registered, possibly inverted, data and qualifier
//   err_flag                 d_out was inverted on this bit
//   frame_done               last bit of a complete frame
//   err_count                saturating count of inverted bits
// Macro ERR_INJECT_LFSR_EN enables the LFSR-driven mode 11; otherwise mode 11 passes data.
module error_inject_serial_p
  import err_inj_pkg::*;
#(
  parameter  int FRAME_LEN = 7,
  parameter  int CNT_W     = 16,
  localparam int POS_W     = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_in,
  input  logic                 strobe_in,
  input  logic                 frame_start,
  input  logic [1:0]           mode,
  input  logic [FRAME_LEN-1:0] error_mask,
  input  logic [POS_W-1:0]     error_pos,
  input  logic [POS_W-1:0]     burst_len,
  output logic                 d_out,
  output logic                 strobe_out,
  output logic                 err_flag,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     err_count
);

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(FRAME_LEN - 1);

  state_t               state, state_nx;
  logic [POS_W-1:0]     cnt, cnt_nx;
  logic                 latch_cfg;

  logic [1:0]           mode_q;
  logic [FRAME_LEN-1:0] mask_q;
  logic [POS_W-1:0]     pos_q, len_q;

  // Effective config for the current bit: a frame-start bit uses the live
  // inputs, because they are being latched on this very edge.
  logic [1:0]           mode_e;
  logic [FRAME_LEN-1:0] mask_e;
  logic [POS_W-1:0]     pos_e, len_e;
  logic [POS_W-1:0]     idx;
  logic [POS_W:0]       burst_end;
  logic                 burst_hit;
  logic                 inv_sel;
  logic                 inv;
  logic                 done;

  assign mode_e = frame_start ? mode       : mode_q;
  assign mask_e = frame_start ? error_mask : mask_q;
  assign pos_e  = frame_start ? error_pos  : pos_q;
  assign len_e  = frame_start ? burst_len  : len_q;
  assign idx    = frame_start ? '0         : cnt;

  // One extra bit so pos+len cannot wrap; indices past the frame simply
  // never occur, which clips the burst at the frame end.
  assign burst_end = {1'b0, pos_e} + {1'b0, len_e};
  assign burst_hit = ({1'b0, idx} >= {1'b0, pos_e}) && ({1'b0, idx} < burst_end);

`ifdef ERR_INJECT_LFSR_EN
  logic [15:0]      lfsr_value;
  logic [POS_W-1:0] rpos_now, rpos_q, rpos_e;

  err_inj_lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (strobe_in & frame_start),
    .value   (lfsr_value)
  );

  // Position is taken from the pre-advance value at frame start.
  assign rpos_now = POS_W'(lfsr_value % 16'(FRAME_LEN));
  assign rpos_e   = frame_start ? rpos_now : rpos_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rpos_q <= '0;
    end else if (latch_cfg) begin
      rpos_q <= rpos_now;
    end
  end
`endif

  always_comb begin
    inv_sel = 1'b0;
    case (mode_e)
      MODE_MASK:  inv_sel = mask_e[idx];
      MODE_BURST: inv_sel = burst_hit;
`ifdef ERR_INJECT_LFSR_EN
      MODE_LFSR:  inv_sel = (idx == rpos_e);
`endif
      default:    inv_sel = 1'b0;
    endcase
  end

  // Next-state and per-bit decisions
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    latch_cfg = 1'b0;
    inv       = 1'b0;
    done      = 1'b0;
    if (strobe_in) begin
      if (frame_start) begin
        // Also covers a mid-frame restart: the old frame is dropped silently.
        latch_cfg = 1'b1;
        inv       = inv_sel;
        state_nx  = ST_ACTIVE;
        cnt_nx    = POS_W'(1);
      end else if (state == ST_ACTIVE) begin
        inv = inv_sel;
        if (cnt == LAST_IDX) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_PASS;
      mask_q <= '0;
      pos_q  <= '0;
      len_q  <= '0;
    end else if (latch_cfg) begin
      mode_q <= mode;
      mask_q <= error_mask;
      pos_q  <= error_pos;
      len_q  <= burst_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out      <= 1'b0;
      strobe_out <= 1'b0;
      err_flag   <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= '0;
    end else begin
      d_out      <= strobe_in & (d_in ^ inv);
      strobe_out <= strobe_in;
      err_flag   <= inv;
      frame_done <= done;
      if (inv && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule
